fact_ctrl: RTL and testbench

- Iterative factorial engine: accepts an operand n on a go/done handshake and computes n! by repeated multiply-and-decrement, one multiply per clock.
- Owns the sequencing FSM that drives the product-register source select: load constant 1 on start, feed back the product otherwise.
- Top-level compute block of the factorial design; the rest of the design sees only start, operand, result and status.

---
 rtl/fact_pkg.sv | 14 +
 rtl/fact_dp.sv | 42 ++++
 rtl/fact_ctrl.sv | 81 ++++++++
 tb/tb_fact_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and default widths for the factorial engine.
// Imported by the control FSM and the datapath.
package fact_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int N_WIDTH_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: down-counter, product register with
// load/feedback select, and sticky overflow detection.
module fact_dp
  import fact_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_WIDTH    = N_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [N_WIDTH-1:0]    n,
  output logic [N_WIDTH-1:0]    cnt,
  output logic [DATA_WIDTH-1:0] product,
  output logic                  overflow
);

  localparam int FW = 2 * DATA_WIDTH;

  logic [FW-1:0] full;

  assign full = FW'(product) * FW'(cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      product  <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      cnt      <= n;
      product  <= DATA_WIDTH'(1);
      overflow <= 1'b0;
    end else if (step) begin
      cnt      <= cnt - N_WIDTH'(1);
      product  <= full[DATA_WIDTH-1:0];
      // any bit above the product width means truncation happened
      overflow <= overflow | (|full[FW-1:DATA_WIDTH]);
    end
  end

endmodule

// File: rtl/fact_ctrl.sv
// Iterative factorial engine: go/done handshake, one multiply
// per clock, sequencing FSM driving the datapath strobes.
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_WIDTH    = N_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [N_WIDTH-1:0]    n,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow
);

  state_t             state;
  logic [N_WIDTH-1:0] cnt;
  logic               load;
  logic               step;

  assign load = (state == ST_IDLE) && go;
  assign step = (state == ST_MULT);

  fact_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .N_WIDTH   (N_WIDTH)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .n       (n),
    .cnt     (cnt),
    .product (result),
    .overflow(overflow)
  );

  // busy/done are registered alongside the state they decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            busy <= 1'b1;
            if (n > N_WIDTH'(1)) begin
              state <= ST_MULT;
              done  <= 1'b0;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_MULT: begin
          if (cnt == N_WIDTH'(2)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_ctrl.sv
// Self-checking bench for fact_ctrl: vector table plus
// hand sequences, results checked through a scoreboard queue.
module tb_fact_ctrl;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic [3:0]  n;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;

  fact_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .n       (n),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          nv;
    logic [31:0] res;
    logic        ovf;
    int          acc;
  } exp_t;

  typedef struct {
    int          nv;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model(input int nv, output logic [31:0] r,
                                output logic o);
    logic [63:0] f;
    f = 64'd1;
    for (int i = 2; i <= nv; i++) f = f * 64'(i);
    r = f[31:0];
    o = (f[63:32] != 32'd0);
  endfunction

  // scoreboard: every done pulse pops one expected operation
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("result_n%0d", e.nv), 64'(result), 64'(e.res));
        chk($sformatf("ovf_n%0d", e.nv), 64'(overflow), 64'(e.ovf));
        chk($sformatf("latency_n%0d", e.nv), 64'(cyc - e.acc),
            64'((e.nv > 1) ? e.nv - 1 : 0));
      end
    end
  end

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 64) begin
      @(negedge clk); #1;
      i++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input int nv, input logic [31:0] r, input logic o);
    n  = 4'(nv);
    go = 1'b1;
    sb.push_back('{nv, r, o, cyc + 1});
    @(negedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int i;
    i = 0;
    while (done_cnt == prev && i < 64) begin
      @(negedge clk); #1;
      i++;
    end
    chk("done_seen", 64'(done_cnt - prev), 64'd1);
    @(negedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic run_op(input int nv, input logic [31:0] r, input logic o);
    int prev;
    wait_idle();
    prev = done_cnt;
    issue(nv, r, o);
    wait_done(prev);
  endtask

  initial begin
    vec_t        vecs[7];
    int          prev;
    logic [31:0] mr;
    logic        mo;

    vecs[0] = '{12, 32'd479001600, 1'b0};
    vecs[1] = '{13, 32'd1932053504, 1'b1};
    vecs[2] = '{3, 32'd6, 1'b0};
    vecs[3] = '{2, 32'd2, 1'b0};
    vecs[4] = '{10, 32'd3628800, 1'b0};
    vecs[5] = '{14, 32'd1278945280, 1'b1};
    vecs[6] = '{15, 32'd2004310016, 1'b1};

    rst_n = 1'b0;
    go    = 1'b0;
    n     = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // n=5: busy across E0..E4, low after E5
    prev = done_cnt;
    issue(5, 32'd120, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("busy_n5_e%0d", k), 64'(busy), 64'd1);
      @(negedge clk); #1;
    end
    chk("n5_done_count", 64'(done_cnt - prev), 64'd1);
    chk("n5_done_low", 64'(done), 64'd0);
    chk("n5_busy_low", 64'(busy), 64'd0);

    // n=0 then n=1 with go held high
    wait_idle();
    prev = done_cnt;
    n  = 4'd0;
    go = 1'b1;
    sb.push_back('{0, 32'd1, 1'b0, cyc + 1});
    @(negedge clk); #1;
    n = 4'd1;
    sb.push_back('{1, 32'd1, 1'b0, cyc + 2});
    @(negedge clk); #1;
    @(negedge clk); #1;
    go = 1'b0;
    @(negedge clk); #1;
    chk("b2b_done_count", 64'(done_cnt - prev), 64'd2);

    // table vectors
    for (int i = 0; i < 7; i++)
      run_op(vecs[i].nv, vecs[i].res, vecs[i].ovf);

    // sweep every operand against the reference model
    for (int v = 0; v < 16; v++) begin
      model(v, mr, mo);
      run_op(v, mr, mo);
    end

    // go pulse while busy is ignored
    wait_idle();
    prev = done_cnt;
    issue(6, 32'd720, 1'b0);
    @(negedge clk); #1;
    go = 1'b1;
    n  = 4'd2;
    @(negedge clk); #1;
    go = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("busy_go_done_count", 64'(done_cnt - prev), 64'd1);
    chk("busy_go_idle", 64'(busy), 64'd0);

    // reset mid-operation aborts with no done
    wait_idle();
    prev = done_cnt;
    issue(15, 32'd2004310016, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_ovf", 64'(overflow), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    sb.delete();
    repeat (20) @(negedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - prev), 64'd0);
    run_op(4, 32'd24, 1'b0);

    // result hold while idle
    run_op(7, 32'd5040, 1'b0);
    for (int k = 0; k < 10; k++) begin
      n = 4'($urandom_range(0, 15));
      @(negedge clk); #1;
      chk("hold_result", 64'(result), 64'd5040);
      chk("hold_busy", 64'(busy), 64'd0);
    end
    chk("hold_ovf", 64'(overflow), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
